fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameters (name, default, meaning): INS_W, 16, instruction width (4 opcode + 4 des + 4 source1 + 4 source2).
REQ-002 Parameter: PC_W, 8, program counter width.
REQ-003 Parameter: DEPTH, 8, queue entries (power of two).
REQ-004 Ports (name, direction, width, meaning): clk  in  1  the single clock, all state updates on its rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 imem_req  out  1  instruction memory read request.
REQ-007 imem_addr  out  PC_W  read address, meaningful only while imem_req=1.
REQ-008 imem_data  in  INS_W  read data, valid exactly one cycle after the request.
REQ-009 redirect  in  1  branch-resolution redirect/flush.
REQ-010 redirect_pc  in  PC_W  redirect target.
REQ-011 out_valid0, out_valid1  out  1 each  decode slot 0 (oldest) and slot 1 valid.
REQ-012 out_ins0, out_ins1  out  INS_W each  slot instructions; out_pc0, out_pc1  out  PC_W each  slot PCs.
REQ-013 dec_take  in  2  number of slots decode consumes this cycle (0, 1 or 2).
REQ-014 count  out  4  current occupancy, 0..DEPTH.
REQ-015 halted  out  1  high while fetch is in HALTED state.

Function
REQ-016 The queue SHALL be a circular buffer of {ins, pc} entries with head/tail pointers wrapping modulo DEPTH.
REQ-017 The FSM SHALL have states FETCH and HALTED; halted=1 only in HALTED.
REQ-018 In FETCH, imem_req SHALL be 1 iff count + inflight < DEPTH and redirect=0, where inflight is the 1-bit outstanding-request flag.
REQ-019 On a request, imem_addr SHALL equal pc, and pc SHALL increment by 1, wrapping modulo 2^PC_W.
REQ-020 One cycle after a non-squashed request, imem_data and its request PC SHALL be written at tail, and tail SHALL advance.
REQ-021 A written instruction with opcode 4'hF (HALT) SHALL be enqueued normally and SHALL move the FSM to HALTED; no further requests are issued.
REQ-022 HALTED SHALL exit to FETCH only on redirect.
REQ-023 out_valid0 SHALL be (count>=1); out_valid1 SHALL be (count>=2); slot data SHALL be taken from head and head+1 (wrapped).
REQ-024 The queue SHALL pop min(dec_take, count) entries; dec_take=3 SHALL be treated as 2.
REQ-025 Push and pop in the same cycle SHALL both take effect: count_next = count + push - pop.
REQ-026 On redirect=1 at a clock edge: count, head and tail <= 0; pc <= redirect_pc; state <= FETCH; the in-flight return SHALL be discarded; dec_take SHALL be ignored; imem_req=0 in that cycle.
REQ-027 The first request after a redirect SHALL occur in the following cycle, with imem_addr=redirect_pc.
REQ-028 When count=DEPTH, no write SHALL occur and no request is outstanding (guaranteed by REQ-018).
REQ-029 When count=0, both out_valid outputs SHALL be 0 and dec_take SHALL have no effect.

Reset
REQ-030 When rst_n=0 at a rising edge: pc=0, head=tail=count=0, inflight=0, state=FETCH; any in-flight data is discarded.
REQ-031 Reset values: imem_req=0, out_valid0=out_valid1=0, halted=0.
REQ-032 Reset SHALL override a simultaneous redirect or dec_take.
REQ-033 Reset asserted mid-operation SHALL leave no residual queue entries.
REQ-034 imem_req SHALL first assert in the cycle after rst_n rises, with imem_addr=0.

Verification
REQ-035 Release reset, memory returns addr+16'h0100, dec_take=0 -> requests at addrs 0..7, count reaches 8, imem_req then held 0; out_ins0=16'h0100, out_ins1=16'h0101.
REQ-036 Full queue, dec_take=2 for one cycle -> count 8->6, out_pc0=2; new requests resume so that count+inflight<=8.
REQ-037 Steady state with dec_take=1 -> one push and one pop per cycle, count constant, PCs delivered in order across head/tail wrap.
REQ-038 Redirect to pc=8'h40 while count=5 and a request is in flight -> count=0 next cycle, stale return dropped, next imem_addr=8'h40.
REQ-039 Memory returns 16'hF000 at pc 3 -> halted=1, no requests after pc 3, queue still drains to decode; redirect to 8'h10 -> halted=0 and fetch resumes at 8'h10.
REQ-040 pc=8'hFF fetch -> next imem_addr=8'h00 (wrap); rst_n=0 mid-stream -> all outputs take reset values next cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch unit feeding a circular {ins, pc} queue that presents up to
// two oldest entries to decode; a HALT opcode parks fetch until a redirect.
module fetch_queue #(
  parameter int INS_W = 16,
  parameter int PC_W  = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_data,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             out_valid0,
  output logic             out_valid1,
  output logic [INS_W-1:0] out_ins0,
  output logic [INS_W-1:0] out_ins1,
  output logic [PC_W-1:0]  out_pc0,
  output logic [PC_W-1:0]  out_pc1,
  input  logic [1:0]       dec_take,
  output logic [3:0]       count,
  output logic             halted
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [3:0]      count_q, count_d;
  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;

  logic [INS_W-1:0] ins_mem_q [DEPTH];
  logic [PC_W-1:0]  pc_mem_q  [DEPTH];

  logic [1:0]    take_eff;
  logic [1:0]    pop;
  logic          push;
  logic          wr_en;
  logic          halt_ret;
  logic [AW-1:0] head_p1;

  assign head_p1    = head_q + AW'(1);
  assign imem_addr  = pc_q;
  assign count      = count_q;
  assign halted     = (state_q == HALTED);
  assign out_valid0 = (count_q != 4'd0);
  assign out_valid1 = (count_q >= 4'd2);
  assign out_ins0   = ins_mem_q[head_q];
  assign out_ins1   = ins_mem_q[head_p1];
  assign out_pc0    = pc_mem_q[head_q];
  assign out_pc1    = pc_mem_q[head_p1];

  always_comb begin
    take_eff = (dec_take == 2'd3) ? 2'd2 : dec_take;
    pop      = ({2'b00, take_eff} <= count_q) ? take_eff : count_q[1:0];
    push     = inflight_q;
    // A returning HALT must also block the request issued alongside its write.
    halt_ret = push && (imem_data[INS_W-1 -: 4] == 4'hF);
    imem_req = rst_n && (state_q == FETCH) && !redirect && !halt_ret &&
               (({1'b0, count_q} + {4'b0000, inflight_q}) < 5'(DEPTH));
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    req_pc_d   = req_pc_q;
    wr_en      = 1'b0;
    if (redirect) begin
      state_d    = FETCH;
      pc_d       = redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = 4'd0;
      inflight_d = 1'b0;
    end else begin
      head_d  = head_q + AW'(pop);
      count_d = count_q + {3'b000, push} - {2'b00, pop};
      if (push) begin
        wr_en  = 1'b1;
        tail_d = tail_q + AW'(1);
      end
      if (halt_ret) begin
        state_d = HALTED;
      end
      inflight_d = imem_req;
      if (imem_req) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + PC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 4'd0;
      inflight_q <= 1'b0;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      req_pc_q   <= req_pc_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      ins_mem_q[tail_q] <= imem_data;
      pc_mem_q[tail_q]  <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomized checks of fetch_queue against a queue-based reference
// model of fetch, enqueue, decode pop, redirect, halt and reset behaviour.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        out_valid0, out_valid1;
  logic [15:0] out_ins0, out_ins1;
  logic [7:0]  out_pc0, out_pc1;
  logic [1:0]  dec_take;
  logic [3:0]  count;
  logic        halted;

  int tests = 0;
  int fails = 0;

  logic [23:0] mq[$];
  logic [7:0]  m_pc = 8'd0;
  logic        m_infl = 1'b0;
  logic [7:0]  m_ia = 8'd0;
  logic        m_halted = 1'b0;
  logic        halt_en = 1'b0;
  logic [7:0]  halt_addr = 8'd0;
  bit          checks_on = 1'b0;

  always #5 clk = ~clk;

  fetch_queue #(.INS_W(16), .PC_W(8), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_ins0(out_ins0), .out_ins1(out_ins1), .out_pc0(out_pc0), .out_pc1(out_pc1),
    .dec_take(dec_take), .count(count), .halted(halted)
  );

  function automatic logic [15:0] mem_f(input logic [7:0] a);
    return (halt_en && a == halt_addr) ? 16'hF000 : (16'h0100 + {8'h00, a});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare with the model, advance the model at the edge.
  task automatic cycle(input logic rst, input logic redir, input logic [7:0] rpc,
                       input logic [1:0] take);
    logic        exp_req;
    logic [15:0] ret;
    int          n;
    rst_n       = rst;
    redirect    = redir;
    redirect_pc = rpc;
    dec_take    = take;
    ret         = mem_f(m_ia);
    imem_data   = m_infl ? ret : 16'($urandom);
    exp_req = rst && !m_halted && !redir && !(m_infl && ret[15:12] == 4'hF) &&
              ((mq.size() + int'(m_infl)) < 8);
    #2;
    if (checks_on) begin
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("count", 32'(count), 32'(mq.size()));
      chk("valid0", 32'(out_valid0), 32'(mq.size() >= 1));
      chk("valid1", 32'(out_valid1), 32'(mq.size() >= 2));
      chk("halted", 32'(halted), 32'(m_halted));
      if (mq.size() >= 1) begin
        chk("ins0", 32'(out_ins0), 32'(mq[0][23:8]));
        chk("pc0", 32'(out_pc0), 32'(mq[0][7:0]));
      end
      if (mq.size() >= 2) begin
        chk("ins1", 32'(out_ins1), 32'(mq[1][23:8]));
        chk("pc1", 32'(out_pc1), 32'(mq[1][7:0]));
      end
    end
    @(posedge clk);
    if (!rst) begin
      mq.delete(); m_pc = 8'd0; m_infl = 1'b0; m_halted = 1'b0;
    end else if (redir) begin
      mq.delete(); m_pc = rpc; m_infl = 1'b0; m_halted = 1'b0;
    end else begin
      n = (take == 2'd3) ? 2 : int'(take);
      if (n > mq.size()) n = mq.size();
      repeat (n) void'(mq.pop_front());
      if (m_infl) begin
        mq.push_back({ret, m_ia});
        if (ret[15:12] == 4'hF) m_halted = 1'b1;
      end
      if (exp_req) begin
        m_ia = m_pc; m_pc = m_pc + 8'd1; m_infl = 1'b1;
      end else begin
        m_infl = 1'b0;
      end
    end
    checks_on = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 8'd0; dec_take = 2'd0; imem_data = 16'd0;
    #1;
    cycle(1'b0, 1'b1, 8'h55, 2'd2);
    cycle(1'b0, 1'b1, 8'h55, 2'd2);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid0", 32'(out_valid0), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);

    // Fill the queue with decode stalled.
    repeat (12) cycle(1'b1, 1'b0, 8'h00, 2'd0);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_ins0", 32'(out_ins0), 32'h0100);
    chk("fill_ins1", 32'(out_ins1), 32'h0101);
    chk("fill_req", 32'(imem_req), 32'd0);

    cycle(1'b1, 1'b0, 8'h00, 2'd2);
    chk("pop2_count", 32'(count), 32'd6);
    chk("pop2_pc0", 32'(out_pc0), 32'd2);

    repeat (24) cycle(1'b1, 1'b0, 8'h00, 2'd1);
    cycle(1'b1, 1'b0, 8'h00, 2'd3);
    cycle(1'b1, 1'b0, 8'h00, 2'd1);

    cycle(1'b1, 1'b1, 8'h40, 2'd1);
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_valid0", 32'(out_valid0), 32'd0);
    redirect = 1'b0; #1;
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", 32'(imem_addr), 32'h40);
    repeat (6) cycle(1'b1, 1'b0, 8'h00, 2'($urandom_range(0, 3)));

    // HALT returned for pc 3.
    cycle(1'b0, 1'b0, 8'h00, 2'd0);
    halt_en = 1'b1; halt_addr = 8'd3;
    repeat (8) cycle(1'b1, 1'b0, 8'h00, 2'd0);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_count", 32'(count), 32'd4);
    repeat (6) cycle(1'b1, 1'b0, 8'h00, 2'd1);
    chk("halt_drain", 32'(count), 32'd0);
    chk("halt_noreq", 32'(imem_req), 32'd0);
    halt_en = 1'b0;
    cycle(1'b1, 1'b1, 8'h10, 2'd0);
    chk("unhalt", 32'(halted), 32'd0);
    redirect = 1'b0; #1;
    chk("unhalt_addr", 32'(imem_addr), 32'h10);

    // PC wrap.
    cycle(1'b1, 1'b1, 8'hFF, 2'd0);
    cycle(1'b1, 1'b0, 8'h00, 2'd1);
    chk("wrap_addr", 32'(imem_addr), 32'h00);
    repeat (4) cycle(1'b1, 1'b0, 8'h00, 2'd1);

    // Reset in the middle of traffic.
    repeat (5) cycle(1'b1, 1'b0, 8'h00, 2'd0);
    cycle(1'b0, 1'b1, 8'h20, 2'd2);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid1", 32'(out_valid1), 32'd0);
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    cycle(1'b1, 1'b0, 8'h00, 2'd0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        halt_en   = ~halt_en;
        halt_addr = 8'($urandom);
      end
      cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
            8'($urandom), 2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
